// File: rtl/uart_xmt_scheduler_pkg.sv
// uart_xmt_pkg: shared state encoding and widths for the UART transmit scheduler
package uart_xmt_pkg;
  localparam int default_word_size = 8;
  localparam int cnt_w = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    START = 3'd3,
    BUSY  = 3'd4
  } state_t;
endpackage

// File: rtl/uart_xmt_scheduler_if.sv
// uart_xmt_scheduler_if: requester bus plus transmitter strobes of the scheduler
interface uart_xmt_scheduler_if
  import uart_xmt_pkg::*;
#(
  parameter int word_size = default_word_size,
  parameter int num_req = 4
);
  localparam int id_w = $clog2(num_req);
  logic [num_req-1:0] req;
  logic [num_req*word_size-1:0] req_data;
  logic [num_req-1:0] ack;
  logic [num_req-1:0] done;
  logic busy;
  logic [id_w-1:0] active_id;
  logic [word_size-1:0] Data_Bus;
  logic Load_XMT_datareg;
  logic Byte_ready;
  logic T_byte;
  modport master (
    output req, req_data,
    input ack, done, busy, active_id, Data_Bus, Load_XMT_datareg, Byte_ready, T_byte
  );
  modport slave (
    input req, req_data,
    output ack, done, busy, active_id, Data_Bus, Load_XMT_datareg, Byte_ready, T_byte
  );
endinterface

// File: rtl/uart_xmt_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last winner
module rr_arbiter #(
  parameter int num_req = 4,
  parameter int id_w = $clog2(num_req)
) (
  input  logic [num_req-1:0] req,
  input  logic [id_w-1:0]    last,
  output logic [num_req-1:0] grant,
  output logic [id_w-1:0]    idx,
  output logic               valid
);
  always_comb begin
    idx = '0;
    // walk from the farthest offset down so the nearest requester after last wins
    for (int i = num_req; i >= 1; i--)
      if (req[(int'(last) + i) % num_req]) idx = id_w'((int'(last) + i) % num_req);
    valid = |req;
    grant = valid ? num_req'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_xmt_scheduler.sv
// uart_xmt_scheduler: round-robin sharing of one UART transmitter among byte sources
module uart_xmt_scheduler
  import uart_xmt_pkg::*;
#(
  parameter int word_size = default_word_size,
  parameter int num_req = 4,
  parameter int frame_cycles = 12
) (
  input logic Clock,
  input logic rst_b,
  uart_xmt_scheduler_if.slave bus
);
  localparam int id_w = $clog2(num_req);
  state_t state, state_nxt;
  logic [id_w-1:0] last, win, id_q;
  logic [num_req-1:0] grant, onehot;
  logic valid;
  logic [cnt_w-1:0] cnt;
  logic [word_size-1:0] data_q, win_data;
  rr_arbiter #(.num_req(num_req), .id_w(id_w)) u_arb (
    .req(bus.req),
    .last(last),
    .grant(grant),
    .idx(win),
    .valid(valid)
  );
  always_comb begin
    win_data = '0;
    for (int i = 0; i < num_req; i++)
      if (grant[i]) win_data = bus.req_data[i*word_size +: word_size];
  end
  always_ff @(posedge Clock)
    if (!rst_b) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE  ? (valid ? LOAD : IDLE) :
                state == LOAD  ? READY :
                state == READY ? START :
                state == START ? BUSY :
                state == BUSY && cnt != 0 ? BUSY : IDLE;
    onehot = num_req'(1) << id_q;
    bus.ack = state == LOAD ? onehot : '0;
    bus.done = state == BUSY && cnt == 0 ? onehot : '0;
    bus.busy = state != IDLE;
    bus.Load_XMT_datareg = state == LOAD;
    bus.Byte_ready = state == READY;
    bus.T_byte = state == START;
    bus.active_id = id_q;
    bus.Data_Bus = data_q;
  end
  // owner and byte only move on a grant, so they stay frozen for the whole frame
  always_ff @(posedge Clock)
    if (!rst_b) begin
      last <= id_w'(num_req - 1);
      id_q <= '0;
      data_q <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && valid) begin
        last <= win;
        id_q <= win;
        data_q <= win_data;
      end
      cnt <= state == START ? cnt_w'(frame_cycles - 1) :
             state == BUSY && cnt != 0 ? cnt - cnt_w'(1) : cnt;
    end
endmodule

// File: tb/tb_uart_xmt_scheduler.sv
// tb_uart_xmt_scheduler: directed self-checking bench for the transmit scheduler
module tb_uart_xmt_scheduler;
  localparam int WS = 8, NR = 4, FC = 12;
  logic Clock = 0, rst_b = 0;
  int checks = 0, errors = 0;
  logic [21:0] all_out;
  uart_xmt_scheduler_if #(.word_size(WS), .num_req(NR)) bus();
  uart_xmt_scheduler #(.word_size(WS), .num_req(NR), .frame_cycles(FC)) dut (
    .Clock(Clock),
    .rst_b(rst_b),
    .bus(bus)
  );
  assign all_out = {bus.ack, bus.done, bus.busy, bus.active_id, bus.Data_Bus,
                    bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte};
  always #5 Clock = ~Clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic apply_reset();
    rst_b = 0;
    bus.req = '0;
    bus.req_data = '0;
    repeat (2) @(negedge Clock);
    rst_b = 1;
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && bus.busy; i++) @(negedge Clock);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s wait_idle: busy=%b required 0", name, bus.busy); end
  endtask
  task automatic test_reset();
    apply_reset();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset outs=%h required 0", all_out); end
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL idle cycle %0d outs=%h required 0", i, all_out); end
    end
  endtask
  task automatic test_single();
    bus.req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
    bus.req = 4'b0001;
    @(negedge Clock);
    checks++;
    if (bus.ack !== 4'b0001) begin errors++; $display("FAIL single ack=%b required 0001", bus.ack); end
    checks++;
    if (bus.Data_Bus !== 8'hA5) begin errors++; $display("FAIL single data=%h required a5", bus.Data_Bus); end
    checks++;
    if ({bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte} !== 3'b100) begin
      errors++; $display("FAIL single strobes_t1=%b required 100", {bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte});
    end
    bus.req = '0;
    @(negedge Clock);
    checks++;
    if ({bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte, bus.ack} !== 7'b0100000) begin
      errors++; $display("FAIL single strobes_t2=%b required 0100000", {bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte, bus.ack});
    end
    @(negedge Clock);
    checks++;
    if ({bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte} !== 3'b001) begin
      errors++; $display("FAIL single strobes_t3=%b required 001", {bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte});
    end
    for (int k = 4; k <= 15; k++) begin
      @(negedge Clock);
      checks++;
      if (bus.done !== (k == 15 ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL single done at t+%0d = %b required %b", k, bus.done, (k == 15 ? 4'b0001 : 4'b0000));
      end
      checks++;
      if (bus.Data_Bus !== 8'hA5 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL single hold at t+%0d data=%h busy=%b required a5 1", k, bus.Data_Bus, bus.busy);
      end
    end
    @(negedge Clock);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL single busy_t16=%b required 0", bus.busy); end
  endtask
  task automatic test_back_to_back();
    int n;
    logic [7:0] b;
    apply_reset();
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req = 4'b1111;
    n = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge Clock);
      if (bus.ack !== 4'b0000) begin
        checks++;
        if (bus.ack !== 4'(1 << (n % 4))) begin errors++; $display("FAIL b2b grant %0d ack=%b required %b", n, bus.ack, 4'(1 << (n % 4))); end
        checks++;
        if (c != 1 + 16 * n) begin errors++; $display("FAIL b2b grant %0d cycle=%0d required %0d", n, c, 1 + 16 * n); end
        n++;
      end
      if (bus.busy === 1'b1 && n > 0) begin
        b = 8'h11 * 8'(((n - 1) % 4) + 1);
        checks++;
        if (bus.Data_Bus !== b || bus.active_id !== 2'((n - 1) % 4)) begin
          errors++; $display("FAIL b2b hold cycle %0d data=%h id=%0d required %h %0d", c, bus.Data_Bus, bus.active_id, b, (n - 1) % 4);
        end
      end
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL b2b grant_count=%0d required 5", n); end
    bus.req = '0;
    wait_idle("b2b");
  endtask
  task automatic test_fairness();
    bus.req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    bus.req = 4'b0100;
    @(negedge Clock);
    checks++;
    if (bus.ack !== 4'b0100) begin errors++; $display("FAIL fair first ack=%b required 0100", bus.ack); end
    bus.req = '0;
    wait_idle("fair1");
    bus.req = 4'b0101;
    @(negedge Clock);
    checks++;
    if (bus.ack !== 4'b0001 || bus.Data_Bus !== 8'hA1) begin
      errors++; $display("FAIL fair resume ack=%b data=%h required 0001 a1", bus.ack, bus.Data_Bus);
    end
    bus.req = 4'b0100;
    for (int i = 0; i < 40 && bus.ack === 4'b0000; i++) @(negedge Clock);
    while (bus.ack === 4'b0001) @(negedge Clock);
    for (int i = 0; i < 40 && bus.ack === 4'b0000; i++) @(negedge Clock);
    checks++;
    if (bus.ack !== 4'b0100 || bus.Data_Bus !== 8'hC3) begin
      errors++; $display("FAIL fair next ack=%b data=%h required 0100 c3", bus.ack, bus.Data_Bus);
    end
    bus.req = '0;
    wait_idle("fair2");
  endtask
  task automatic test_withdrawal();
    logic seen0;
    seen0 = 0;
    bus.req_data = {8'h00, 8'h00, 8'h66, 8'h5A};
    bus.req = 4'b0001;
    @(negedge Clock);
    checks++;
    if (bus.ack !== 4'b0001) begin errors++; $display("FAIL withdraw ack=%b required 0001", bus.ack); end
    bus.req = '0;
    repeat (3) @(negedge Clock);
    bus.req = 4'b0010;
    @(negedge Clock);
    bus.req = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clock);
      if (bus.done[0] === 1'b1) seen0 = 1;
      checks++;
      if (bus.ack[1] !== 1'b0 || bus.done[1] !== 1'b0) begin
        errors++; $display("FAIL withdraw cycle %0d ack=%b done=%b required bit1 0", i, bus.ack, bus.done);
      end
    end
    checks++;
    if (seen0 !== 1'b1) begin errors++; $display("FAIL withdraw done0_seen=%b required 1", seen0); end
  endtask
  task automatic test_reset_mid();
    bus.req_data = {8'h00, 8'h00, 8'h00, 8'h77};
    bus.req = 4'b0001;
    @(negedge Clock);
    checks++;
    if (bus.ack !== 4'b0001) begin errors++; $display("FAIL midrst ack=%b required 0001", bus.ack); end
    bus.req = '0;
    repeat (9) @(negedge Clock);
    rst_b = 0;
    @(negedge Clock);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midrst outs=%h required 0", all_out); end
    rst_b = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clock);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL midrst after cycle %0d outs=%h required 0", i, all_out); end
    end
    bus.req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
    bus.req = 4'b0001;
    @(negedge Clock);
    checks++;
    if (bus.ack !== 4'b0001 || bus.Data_Bus !== 8'h3C) begin
      errors++; $display("FAIL midrst fresh ack=%b data=%h required 0001 3c", bus.ack, bus.Data_Bus);
    end
    bus.req = '0;
    for (int k = 2; k <= 15; k++) begin
      @(negedge Clock);
      checks++;
      if (bus.done !== (k == 15 ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL midrst fresh done at t+%0d = %b required %b", k, bus.done, (k == 15 ? 4'b0001 : 4'b0000));
      end
    end
    wait_idle("midrst");
  endtask
  initial begin
    bus.req = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_withdrawal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_xmt_scheduler.md
# uart_xmt_scheduler

Round-robin scheduler that shares the single UART transmitter among `num_req` byte sources. It accepts requests, latches the winning byte, and drives the transmitter's `Data_Bus`, `Load_XMT_datareg`, `Byte_ready` and `T_byte` strobes in order. It then holds off the next grant until the serial frame has drained, and pulses `done` to the owning requester. It sits between the host-side producers and the transmitter inside the UART top level.

## Interface
- `word_size`, default 8: width of one data byte.
- `num_req`, default 4: number of requesters, 2..8.
- `frame_cycles`, default 12: Clock cycles the transmitter needs to shift out one frame after `T_byte`. Valid range is `word_size+2`..255.
- `Clock` input, 1 bit: single clock, rising edge.
- `rst_b` input, 1 bit: reset, synchronous and active-low.
- `req` input, `num_req` bits: per-requester request level.
- `req_data` input, `num_req*word_size` bits: byte of requester i at bits `[i*word_size +: word_size]`.
- `ack` output, `num_req` bits: one-hot, one-cycle pulse; the byte has been captured.
- `done` output, `num_req` bits: one-hot, one-cycle pulse; the frame is fully transmitted.
- `busy` output, 1 bit: high in every state except IDLE.
- `active_id` output, `clog2(num_req)` bits: index of the current owner.
- `Data_Bus` output, `word_size` bits: byte to the transmitter.
- `Load_XMT_datareg`, `Byte_ready`, `T_byte` outputs, 1 bit each: transmitter strobes.

## Operation
- States and transitions:
  - IDLE: if any `req` bit is set, go to LOAD; otherwise stay in IDLE.
  - LOAD always goes to READY.
  - READY always goes to START.
  - START always goes to BUSY.
  - BUSY goes to IDLE when the frame counter is 0.
- Arbitration:
  - Evaluated only in IDLE.
  - Round-robin, starting at index `last+1` modulo `num_req`.
  - `last` resets to `num_req-1`, so requester 0 wins first after reset.
- On the IDLE→LOAD edge:
  - Winner's byte latched into the `Data_Bus` register.
  - `active_id` and `last` updated to the winner.
- Strobes:
  - LOAD: `Load_XMT_datareg`=1 and `ack[active_id]`=1.
  - READY: `Byte_ready`=1.
  - START: `T_byte`=1.
  - Each strobe is high for exactly one cycle.
- Frame counter:
  - 8 bits, loaded with `frame_cycles-1` on the START→BUSY edge.
  - Decrements once per cycle in BUSY.
  - At 0: `done[active_id]`=1 for that cycle, then IDLE.
- `Data_Bus` and `active_id` hold their values from LOAD until the next grant; they never change while `busy`=1.
- Requester rules:
  - A requester holds `req` and stable data until it sees `ack`. `req` after `ack` is a new request.
  - A request dropped before it is granted is simply not granted; no error.
  - New requests arriving while `busy`=1 wait; nothing is queued internally beyond the `req` levels.

## Timing
- Reset (`rst_b`=0 at an edge):
  - State goes to IDLE, `last`=`num_req-1`, counter=0.
  - `Data_Bus`=0, `active_id`=0.
  - All strobes, `ack`, `done` and `busy` are 0.
  - Reset mid-frame aborts the frame with no `done`; the transmitter shares `rst_b`.
- All outputs come directly from registers or from a state decode; no combinational path from `req`.
- `req` sampled high in IDLE at edge t:
  - `ack` and `Load_XMT_datareg` at cycle t+1.
  - `Byte_ready` at t+2, `T_byte` at t+3.
  - `done` at t+3+`frame_cycles`.
- Back-to-back service: one IDLE cycle between frames, so a frame slot is `frame_cycles`+4 cycles.
- Simultaneous events: `req` rising in the same cycle as `done` is seen in the following IDLE cycle.

## Structure
- Shared package `uart_xmt_pkg`:
  - State encoding constants (IDLE=0, LOAD=1, READY=2, START=3, BUSY=4, 3 bits).
  - Default `word_size`.
  - Counter width 8.
- Sub-module `rr_arbiter`: combinational one-hot grant from `req` and `last`, plus the binary index of the winner.
- FSM, counter and output registers live in the top of `uart_xmt_scheduler`.

## Test plan
- Reset then idle: after `rst_b` low for 2 cycles, every output is 0 and `busy`=0 for 20 cycles with `req`=0.
- Single request, `req`=0001, data 8'hA5:
  - `ack`=0001 at t+1, `Data_Bus`=8'hA5 from t+1.
  - Strobes at t+1, t+2 and t+3.
  - `done`=0001 at t+15 (`frame_cycles`=12).
- All four requesting continuously with distinct bytes:
  - Grant order 0,1,2,3,0.
  - `ack` edges exactly 16 cycles apart.
  - `Data_Bus` never changes during `busy`.
- Fairness resume: after requester 2 is served, `req`=0101 grants requester 0 (next after 2 is 3, absent, then 0), and requester 2 goes next.
- Withdrawal: `req[1]` pulsed for one cycle while `busy`=1, never seen in IDLE, yields no `ack[1]` and no `done[1]`.
- Reset mid-frame: `rst_b` low during BUSY with counter 5 gives IDLE and all outputs 0 next cycle, with no `done`. A fresh `req`=0001 is then served normally.
